// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the scoreboarded multi-port register file.
//   XLEN_DEF / NREG_DEF : default register width and register count
//   REG_ZERO            : index of the hardwired-zero register
//   slice_lo()          : low bit offset of port <idx> inside a packed port
//                         vector whose slices are <width> bits wide
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;

    // Port i of a packed vector lives at [slice_lo(i, W) +: W].
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Per-register busy tracking for the register file.
//   clk, rst        : clock, asynchronous active-high reset
//   wb_we, wb_addr  : write-back ports; a write releases its register
//   rsv_valid/rsv_rd: reservation request from issue
//   rsv_ok          : combinational acceptance of the reservation
//   flush           : synchronous clear of every busy bit
//   busy_vec        : registered busy bits, bit 0 always 0
// Busy priority per register: rst, flush, reservation, release, hold.
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wb_we,
    input  logic [NWR*AW-1:0] wb_addr,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_rd,
    input  logic              flush,
    output logic              rsv_ok,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] release_s;
    logic [NREG-1:0] set_s;
    logic            rsv_zero_s;

    // Decode the write-back ports into per-register release strobes.
    always_comb begin
        release_s = '0;
        for (int r = 1; r < NREG; r++) begin
            for (int j = 0; j < NWR; j++) begin
                release_s[r] = release_s[r]
                             | (wb_we[j] & (wb_addr[slice_lo(j, AW) +: AW] == AW'(r)));
            end
        end
    end

    // Accept a reservation when the target is free or is released this cycle;
    // only write-back and busy state feed this path, never the read addresses.
    always_comb begin
        rsv_zero_s = (rsv_rd == AW'(REG_ZERO));
        rsv_ok     = rsv_valid & (rsv_zero_s | ~busy_q[rsv_rd] | release_s[rsv_rd]);
    end

    // Next busy state: flush beats reservation, reservation beats release.
    always_comb begin
        set_s         = '0;
        set_s[rsv_rd] = rsv_ok;
        set_s[0]      = 1'b0;
        if (flush) begin
            busy_d = '0;
        end else begin
            busy_d = (busy_q & ~release_s) | set_s;
        end
    end

    // Busy flops with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Multi-port integer register file with same-cycle write bypass and a
// per-register busy scoreboard for RAW/WAW hazard detection.
//   clk, rst  : clock, asynchronous active-high reset (clears data and busy)
//   rs_addr   : NRD read addresses, port i at slice i
//   rs_data   : NRD combinational read data, bypassed from write-back
//   rs_ready  : per read port, register not busy or written this cycle
//   wb_we/wb_addr/wb_data : NWR write-back ports, highest index wins
//   rsv_valid/rsv_rd/rsv_ok : destination reservation handshake
//   flush     : clear all busy bits, data kept
//   busy_vec  : registered busy bits
// Register 0 always reads 0 and ignores writes.
// ---------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_ready,
    input  logic [NWR-1:0]      wb_we,
    input  logic [NWR*AW-1:0]   wb_addr,
    input  logic [NWR*XLEN-1:0] wb_data,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_rd,
    output logic                rsv_ok,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    logic [NWR-1:0]  rd_match_s [NRD];
    logic [XLEN-1:0] rd_val_s   [NRD];
    logic [NRD-1:0]  rd_zero_s;

    // Next array contents: ports applied in ascending order so the highest
    // indexed write to a register is the one that lands.
    always_comb begin
        regs_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
            for (int j = 0; j < NWR; j++) begin
                regs_d[r] = (wb_we[j] && (wb_addr[slice_lo(j, AW) +: AW] == AW'(r)))
                          ? wb_data[slice_lo(j, XLEN) +: XLEN]
                          : regs_d[r];
            end
        end
    end

    // Register array with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // Read-port versus write-port address match matrix.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_zero_s[i] = (rs_addr[slice_lo(i, AW) +: AW] == AW'(REG_ZERO));
            for (int j = 0; j < NWR; j++) begin
                rd_match_s[i][j] = wb_we[j]
                                 & (wb_addr[slice_lo(j, AW) +: AW] == rs_addr[slice_lo(i, AW) +: AW]);
            end
        end
    end

    // Bypass mux per read port; later write ports override earlier ones.
    always_comb begin
        rs_data  = '0;
        rs_ready = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_val_s[i] = regs_q[rs_addr[slice_lo(i, AW) +: AW]];
            for (int j = 0; j < NWR; j++) begin
                rd_val_s[i] = rd_match_s[i][j] ? wb_data[slice_lo(j, XLEN) +: XLEN] : rd_val_s[i];
            end
            rs_data[slice_lo(i, XLEN) +: XLEN] = rd_zero_s[i] ? '0 : rd_val_s[i];
            rs_ready[i] = rd_zero_s[i]
                        | ~busy_vec[rs_addr[slice_lo(i, AW) +: AW]]
                        | (|rd_match_s[i]);
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
        .flush     (flush),
        .rsv_ok    (rsv_ok),
        .busy_vec  (busy_vec)
    );

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with a per-register scoreboard. It is the next generation of the core's two-read/one-write register file. It adds:
- N read and M write-back ports;
- same-cycle write-to-read bypass;
- asynchronous reset of all registers;
- busy tracking so the issue stage can detect RAW and WAW hazards without a separate scoreboard.

It sits between decode/issue (read, reserve) and write-back (write, release).

## Interface
Parameters:
- XLEN, 64, register width in bits
- NREG, 32, number of architectural registers; must be a power of two, at least 2. Register 0 is hardwired to zero.
- NRD, 2, number of read ports
- NWR, 2, number of write-back ports
- AW, $clog2(NREG), derived; not overridden

Ports:
- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- rs_addr  in  NRD*AW  read addresses; port i occupies slice i
- rs_data  out  NRD*XLEN  read data, combinational, bypassed
- rs_ready  out  NRD  1 when the read register is not busy, or is being written this cycle
- wb_we  in  NWR  write-back enables
- wb_addr  in  NWR*AW  write-back addresses
- wb_data  in  NWR*XLEN  write-back data
- rsv_valid  in  1  issue requests reservation of rsv_rd
- rsv_rd  in  AW  destination register to reserve
- rsv_ok  out  1  combinational; 1 when the reservation is accepted this cycle
- flush  in  1  synchronous clear of all busy bits; data is kept
- busy_vec  out  NREG  registered busy bits; bit 0 is always 0

## Operation
Reset (rst=1, asynchronous):
- all registers go to 0 and all busy bits to 0;
- outputs settle to rs_data=0, rs_ready all 1, busy_vec=0, and rsv_ok=rsv_valid.

Reads, per port i (combinational):
- address 0 returns 0 with ready=1;
- otherwise, if any write port j has wb_we[j] and wb_addr[j]==rs_addr[i], return that port's wb_data;
- otherwise return the array contents.
- rs_ready[i] = !busy[addr] or (a matching write is present this cycle).

Write-back:
- on a rising edge, each port with wb_we=1 and a nonzero address writes its data;
- writes to register 0 are dropped;
- if several ports target the same register, the highest-indexed port wins, for both the array and the bypass mux.
- A write clears that register's busy bit, unless a reservation on the same register is accepted in the same cycle (see next).

Reservation:
- rsv_ok = rsv_valid and (rsv_rd==0 or !busy[rsv_rd] or the register is being written this cycle).
- When rsv_ok=1 and rsv_rd!=0, busy[rsv_rd] is set on the next edge. A reservation outranks a same-cycle release, so the bit ends at 1.
- rsv_rd=0 is always accepted and sets nothing.
- A rejected reservation (WAW stall) changes no state; issue holds and retries.

Flush:
- flush=1 clears every busy bit on the edge;
- same-cycle writes still update the array;
- a same-cycle reservation is ignored, although rsv_ok is still reported;
- flush outranks both release and reservation.

Busy-bit priority per register, highest first: rst, flush, reservation, release, hold.

## Timing
- Reads: zero latency. rs_data and rs_ready are pure functions of the address inputs, the write-back inputs and the current state.
- Write-back: visible through bypass in the same cycle and from the array from the next cycle on.
- Busy bit: reservation accepted in cycle t gives busy=1 from t+1. Release in cycle t gives busy=0 from t+1, and the bypassed read in cycle t already shows ready=1.
- rst asserted mid-cycle clears state immediately. Deassertion is synchronised externally; the block has no special requirement on it.
- No combinational path runs from rs_addr to rsv_ok. rsv_ok depends only on rsv_valid, rsv_rd, the wb_* inputs and busy state.

## Structure
- Package regfile_pkg holds:
  - defaults XLEN_DEF=64, NREG_DEF=32;
  - constant REG_ZERO=0;
  - a function for slice extraction of packed port vectors.
- Sub-module regfile_scoreboard holds:
  - the NREG busy flops;
  - the set/clear priority logic;
  - rsv_ok generation.

  It takes the wb_we/wb_addr, rsv_* and flush inputs and outputs busy_vec. The top level holds the array, the write-port priority and the bypass muxes.

## Test plan
- Reset mid-operation: write 0xDEAD to x5, then assert rst asynchronously between edges → rs_data for x5 = 0 immediately and busy_vec = 0.
- Bypass: wb_we[0]=1, wb_addr=7, wb_data=0x1234, rs_addr[1]=7 in the same cycle → rs_data[1]=0x1234. On the next cycle without write-back, still 0x1234.
- Write conflict: both write ports target x3 with 0xAAAA (port 0) and 0xBBBB (port 1) → bypass and array both read 0xBBBB. A write of 0x55 to x0 → x0 still reads 0.
- Scoreboard RAW:
  - reserve x9 (rsv_ok=1) → next cycle busy_vec[9]=1 and a read of x9 gives ready=0;
  - write-back x9=0x77 → same cycle ready=1 with data 0x77, next cycle busy_vec[9]=0.
- WAW and priorities:
  - with x9 busy, reserve x9 with no write-back → rsv_ok=0 and no state change;
  - reserve x9 in the cycle it is written → rsv_ok=1 and busy stays 1;
  - flush with x4 and x9 busy plus a reservation of x4 → busy_vec=0 next cycle.
- Randomised reference-model check over NRD=3, NWR=2, NREG=16, 10k cycles, including resets → array contents, rs_data and busy_vec match the model every cycle.
